// File: rtl/project_mux_pkg.sv
// Shared definitions for the project multiplexer: register offsets, STATUS bit
// positions, the sequencing FSM encoding and a byte-lane write helper.
package project_mux_pkg;

   localparam logic [7:0] OFF_SELECT   = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h04;
   localparam logic [7:0] OFF_OEB_LO   = 8'h08;
   localparam logic [7:0] OFF_OEB_HI   = 8'h0C;
   localparam logic [7:0] OFF_SOFT_RST = 8'h10;
   localparam logic [7:0] OFF_CLR      = 8'h14;

   localparam int ST_BUSY_BIT = 8;
   localparam int ST_BAD_BIT  = 9;
   localparam int ST_DROP_BIT = 10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GUARD = 2'd1,
      S_RESET = 2'd2
   } mux_state_e;

   // Replace only the byte lanes whose select bit is set.
   function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/project_io_crossbar.sv
// Combinational pad crossbar: steers user pads to/from the active project and
// keeps every other project's inputs tied low.
module project_io_crossbar #(
   parameter int NUM_PROJECTS = 8,
   parameter int IO_PADS      = 36
) (
   input  logic [7:0]                      active,
   input  logic                            route_in,
   input  logic                            connect,
   input  logic [IO_PADS-1:0]              io_in,
   input  logic [IO_PADS-1:0]              oeb_force,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_oeb,
   output logic [IO_PADS-1:0]              io_out,
   output logic [IO_PADS-1:0]              io_oeb,
   output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in
);

   // NOTE: every output gets a default before any conditional assignment, so
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      io_out     = '0;
      io_oeb     = '1;
      proj_io_in = '0;
      for (int p = 0; p < NUM_PROJECTS; p++) begin
         if (active == 8'(p)) begin
            if (route_in) proj_io_in[p*IO_PADS +: IO_PADS] = io_in;
            if (connect) begin
               io_out = proj_io_out[p*IO_PADS +: IO_PADS];
               io_oeb = proj_io_oeb[p*IO_PADS +: IO_PADS] | oeb_force;
            end
         end
      end
   end

endmodule

// File: rtl/project_mux_ctrl.sv
// Wishbone-controlled project multiplexer: register file, guard/reset
// sequencing FSM and per-project reset generation around the pad crossbar.
module project_mux_ctrl
   import project_mux_pkg::*;
#(
   parameter int          NUM_PROJECTS = 8,
   parameter int          IO_PADS      = 36,
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
   parameter int          GUARD_CYCLES = 4,
   parameter int          RST_CYCLES   = 8
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_n,
   input  logic                            wbs_stb_i,
   input  logic                            wbs_cyc_i,
   input  logic                            wbs_we_i,
   input  logic [3:0]                      wbs_sel_i,
   input  logic [31:0]                     wbs_dat_i,
   input  logic [31:0]                     wbs_adr_i,
   output logic                            wbs_ack_o,
   output logic [31:0]                     wbs_dat_o,
   input  logic [IO_PADS-1:0]              io_in,
   output logic [IO_PADS-1:0]              io_out,
   output logic [IO_PADS-1:0]              io_oeb,
   output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_oeb,
   output logic [NUM_PROJECTS-1:0]         proj_rst_n
);

   localparam int HI_W    = IO_PADS - 32;
   localparam int MAX_CYC = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   mux_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       active_q, select_q;
   logic [31:0]      oeb_lo_q;
   logic [HI_W-1:0]  oeb_hi_q;
   logic             bad_sel_q, drop_sel_q;

   logic             wb_valid, rd_req, wr_req;
   logic [7:0]       reg_off;
   logic             sel_wr, soft_wr, clr_wr, sel_ok, busy;
   logic             accept_sel, accept_soft;
   logic [31:0]      rdata, lo_next;
   logic [HI_W-1:0]  hi_next;
   logic             route_in, connect;

   // A request is serviced only on its first cycle; the ack itself blocks a re-issue.
   assign wb_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign rd_req   = wb_valid & ~wbs_ack_o & ~wbs_we_i;
   assign wr_req   = wb_valid & ~wbs_ack_o & wbs_we_i;
   assign reg_off  = wbs_adr_i[7:0];

   assign sel_wr  = wr_req & (reg_off == OFF_SELECT)   & wbs_sel_i[0];
   assign soft_wr = wr_req & (reg_off == OFF_SOFT_RST) & wbs_sel_i[0];
   assign clr_wr  = wr_req & (reg_off == OFF_CLR)      & wbs_sel_i[0] & wbs_dat_i[0];
   assign sel_ok  = ({1'b0, wbs_dat_i[7:0]} < 9'(NUM_PROJECTS));
   assign busy    = (state_q != S_IDLE);

   assign accept_sel  = sel_wr & ~busy & sel_ok;
   assign accept_soft = soft_wr & ~busy;

   assign lo_next = apply_sel(oeb_lo_q, wbs_dat_i, wbs_sel_i);
   assign hi_next = HI_W'(apply_sel(32'(oeb_hi_q), wbs_dat_i, wbs_sel_i));

   always_comb begin
      rdata = '0;
      case (reg_off)
         OFF_SELECT: rdata = {24'd0, select_q};
         OFF_STATUS: begin
            rdata[7:0]         = active_q;
            rdata[ST_BUSY_BIT] = busy;
            rdata[ST_BAD_BIT]  = bad_sel_q;
            rdata[ST_DROP_BIT] = drop_sel_q;
         end
         OFF_OEB_LO: rdata = oeb_lo_q;
         OFF_OEB_HI: rdata = 32'(oeb_hi_q);
         default:    rdata = '0;
      endcase
   end

   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
         active_q   <= '0;
         select_q   <= '0;
         oeb_lo_q   <= '0;
         oeb_hi_q   <= '0;
         bad_sel_q  <= 1'b0;
         drop_sel_q <= 1'b0;
      end else begin
         wbs_ack_o <= wb_valid & ~wbs_ack_o;
         wbs_dat_o <= rd_req ? rdata : '0;
         if (sel_wr)     select_q <= wbs_dat_i[7:0];
         if (accept_sel) active_q <= wbs_dat_i[7:0];
         if (wr_req && reg_off == OFF_OEB_LO) oeb_lo_q <= lo_next;
         if (wr_req && reg_off == OFF_OEB_HI) oeb_hi_q <= hi_next;
         if (sel_wr && !busy && !sel_ok) bad_sel_q <= 1'b1;
         else if (clr_wr)                bad_sel_q <= 1'b0;
         if ((sel_wr || soft_wr) && busy) drop_sel_q <= 1'b1;
         else if (clr_wr)                 drop_sel_q <= 1'b0;
      end
   end

   // Reset lands in RESET so project 0 gets a clean reset pulse after release.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept_sel) begin
               state_d = S_GUARD;
               cnt_d   = '0;
            end else if (accept_soft) begin
               state_d = S_RESET;
               cnt_d   = '0;
            end
         end
         S_GUARD: begin
            if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
               state_d = S_RESET;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESET: begin
            if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_RESET;
            cnt_d   = '0;
         end
      endcase
   end

   // Gating with reset isolates everything combinationally while reset is low.
   assign route_in = wb_rst_n & (state_q != S_GUARD);
   assign connect  = wb_rst_n & (state_q == S_IDLE);

   always_comb begin
      proj_rst_n = '0;
      for (int p = 0; p < NUM_PROJECTS; p++) begin
         if (connect && active_q == 8'(p)) proj_rst_n[p] = 1'b1;
      end
   end

   project_io_crossbar #(
      .NUM_PROJECTS (NUM_PROJECTS),
      .IO_PADS      (IO_PADS)
   ) u_crossbar (
      .active      (active_q),
      .route_in    (route_in),
      .connect     (connect),
      .io_in       (io_in),
      .oeb_force   ({oeb_hi_q, oeb_lo_q}),
      .proj_io_out (proj_io_out),
      .proj_io_oeb (proj_io_oeb),
      .io_out      (io_out),
      .io_oeb      (io_oeb),
      .proj_io_in  (proj_io_in)
   );

endmodule
